// File: rtl/pll_reconfig_seq.sv
// PLL retune sequencer. Takes one retune request and writes it into the PLL
// reconfiguration core over its Avalon-MM management port in a fixed order
// (mode, N, M, K, C, start). It then waits a settle period and polls for
// relock, and reports done or timeout with a single-cycle pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a request, bus quiet
// MODE      | writing waitrequest mode (addr 0x00)
// WR_N      | writing N counter image (addr 0x03)
// WR_M      | writing M counter image (addr 0x04)
// WR_K      | writing fractional K (addr 0x07)
// WR_C      | writing selected C counter image (addr 0x05)
// START     | writing start (addr 0x02)
// SETTLE    | fixed wait after start, pll_locked ignored
// WAIT_LOCK | polling pll_locked against the lock timeout
// FIN       | done or timeout pulse is on the outputs

module pll_reconfig_seq #(
   parameter int SETTLE_CYCLES = 16,
   parameter int LOCK_TIMEOUT  = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_mask,
   input  logic [17:0] req_n,
   input  logic [17:0] req_m,
   input  logic [31:0] req_k,
   input  logic [4:0]  req_c_sel,
   input  logic [17:0] req_c,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked,
   output logic        busy,
   output logic        done,
   output logic        timeout
);

   typedef enum logic [3:0] {
      IDLE, MODE, WR_N, WR_M, WR_K, WR_C, START, SETTLE, WAIT_LOCK, FIN
   } state_t;

   localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES - 1);
   localparam logic [23:0] LOCK_LAST   = 24'(LOCK_TIMEOUT - 1);

   state_t      state;
   state_t      nxt_wr;
   logic [5:0]  nxt_addr;
   logic [31:0] nxt_data;
   logic [23:0] cnt;
   logic [3:0]  mask_q;
   logic [17:0] n_q;
   logic [17:0] m_q;
   logic [31:0] k_q;
   logic [4:0]  c_sel_q;
   logic [17:0] c_q;

   // First enabled write strictly after 'from'; START when none remain.
   function automatic state_t next_wr(input state_t from, input logic [3:0] msk);
      state_t nx;
      nx = START;
      if (msk[3] && (from < WR_C)) nx = WR_C;
      if (msk[2] && (from < WR_K)) nx = WR_K;
      if (msk[1] && (from < WR_M)) nx = WR_M;
      if (msk[0] && (from < WR_N)) nx = WR_N;
      return nx;
   endfunction

   // Address/data of the write that follows the current one, so a chain of
   // writes goes out back to back with no idle bus cycle between them.
   always_comb begin
      nxt_wr   = next_wr(state, mask_q);
      nxt_addr = 6'h02;
      nxt_data = 32'd1;
      case (nxt_wr)
         WR_N: begin
            nxt_addr = 6'h03;
            nxt_data = {14'b0, n_q};
         end
         WR_M: begin
            nxt_addr = 6'h04;
            nxt_data = {14'b0, m_q};
         end
         WR_K: begin
            nxt_addr = 6'h07;
            nxt_data = k_q;
         end
         WR_C: begin
            nxt_addr = 6'h05;
            nxt_data = {9'b0, c_sel_q, c_q};
         end
         default: ;
      endcase
   end

   // Sequencer FSM with registered bus and status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_ready      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         timeout        <= 1'b0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
         cnt            <= '0;
         mask_q         <= '0;
         n_q            <= '0;
         m_q            <= '0;
         k_q            <= '0;
         c_sel_q        <= '0;
         c_q            <= '0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  mask_q    <= req_mask;
                  n_q       <= req_n;
                  m_q       <= req_m;
                  k_q       <= req_k;
                  c_sel_q   <= req_c_sel;
                  c_q       <= req_c;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (req_mask == 4'b0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state          <= MODE;
                     mgmt_write     <= 1'b1;
                     mgmt_address   <= 6'h00;
                     mgmt_writedata <= 32'd0;
                  end
               end
            end
            MODE, WR_N, WR_M, WR_K, WR_C: begin
               if (!mgmt_waitrequest) begin
                  state          <= nxt_wr;
                  mgmt_address   <= nxt_addr;
                  mgmt_writedata <= nxt_data;
               end
            end
            START: begin
               if (!mgmt_waitrequest) begin
                  state          <= SETTLE;
                  mgmt_write     <= 1'b0;
                  mgmt_address   <= '0;
                  mgmt_writedata <= '0;
                  cnt            <= SETTLE_LOAD;
               end
            end
            SETTLE: begin
               if (cnt == 24'd0) begin
                  state <= WAIT_LOCK;
               end else begin
                  cnt <= cnt - 24'd1;
               end
            end
            WAIT_LOCK: begin
               // Lock on the limit cycle still counts as success.
               if (pll_locked) begin
                  state <= FIN;
                  done  <= 1'b1;
                  cnt   <= '0;
               end else if (cnt == LOCK_LAST) begin
                  state   <= FIN;
                  timeout <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 24'd1;
               end
            end
            FIN: begin
               state     <= IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Bench for pll_reconfig_seq: directed retune cases plus randomized requests,
// stalls and lock timing, checked cycle by cycle against a reference model.

module tb_pll_reconfig_seq;

   localparam int SC = 16;
   localparam int LT = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_mask;
   logic [17:0] req_n;
   logic [17:0] req_m;
   logic [31:0] req_k;
   logic [4:0]  req_c_sel;
   logic [17:0] req_c;
   logic [5:0]  mgmt_address;
   logic        mgmt_write;
   logic [31:0] mgmt_writedata;
   logic        mgmt_waitrequest;
   logic        pll_locked;
   logic        busy;
   logic        done;
   logic        timeout;

   int n_cmp = 0;
   int n_err = 0;

   pll_reconfig_seq #(.SETTLE_CYCLES(SC), .LOCK_TIMEOUT(LT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_mask         (req_mask),
      .req_n            (req_n),
      .req_m            (req_m),
      .req_k            (req_k),
      .req_c_sel        (req_c_sel),
      .req_c            (req_c),
      .mgmt_address     (mgmt_address),
      .mgmt_write       (mgmt_write),
      .mgmt_writedata   (mgmt_writedata),
      .mgmt_waitrequest (mgmt_waitrequest),
      .pll_locked       (pll_locked),
      .busy             (busy),
      .done             (done),
      .timeout          (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // One request from an idle DUT. Called at posedge+1. lock_d: wait-lock
   // cycle on which pll_locked is first high (<0 = never).
   task automatic run_req(input logic [3:0] mask, input logic [17:0] n_v,
                          input logic [17:0] m_v, input logic [31:0] k_v,
                          input logic [4:0] cs_v, input logic [17:0] c_v,
                          input int stall_pct, input bit stall_m5,
                          input int lock_d, input bit glitch);
      logic [37:0] q[$];
      logic [37:0] w;
      logic [5:0]  pa;
      logic [31:0] pd;
      int          e, s, t, m_hold, m_cnt;
      bit          s_known, t_known, succ, prev_stall, fin;

      // Reference model: ordered write list from the mask.
      q.delete();
      q.push_back({6'h00, 32'd0});
      if (mask[0]) q.push_back({6'h03, 32'(n_v)});
      if (mask[1]) q.push_back({6'h04, 32'(m_v)});
      if (mask[2]) q.push_back({6'h07, k_v});
      if (mask[3]) q.push_back({6'h05, 32'(cs_v) * 32'h40000 + 32'(c_v)});
      q.push_back({6'h02, 32'd1});

      req_mask = mask; req_n = n_v; req_m = m_v; req_k = k_v;
      req_c_sel = cs_v; req_c = c_v; req_valid = 1'b1;
      mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
      s = 0; t = 0; m_hold = 0; m_cnt = 0;
      s_known = 0; t_known = 0; succ = 0; prev_stall = 0; fin = 0;
      pa = '0; pd = '0;

      @(negedge clk);
      chk("ready_idle", req_ready, 1);
      @(posedge clk);
      e = 1;
      if (mask == 4'b0) begin
         q.delete();
         t = 1; t_known = 1; succ = 1;
      end

      for (int i = 0; i < 400 && !fin; i++) begin
         #1;
         req_valid = (!t_known || e < t) ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (req_valid) begin
            req_mask = 4'($urandom); req_n = 18'($urandom); req_m = 18'($urandom);
            req_k = $urandom; req_c_sel = 5'($urandom); req_c = 18'($urandom);
         end
         if (stall_m5 && mgmt_write && mgmt_address == 6'h04 && m_hold < 5) begin
            mgmt_waitrequest = 1'b1;
            m_hold++;
         end else begin
            mgmt_waitrequest = ($urandom_range(0, 99) < stall_pct);
         end
         if (s_known && e >= s + SC)
            pll_locked = (lock_d >= 0) && (e >= s + SC + lock_d);
         else
            pll_locked = glitch ? 1'($urandom_range(0, 1)) : 1'b0;

         @(negedge clk);
         chk("busy", busy, !(t_known && e > t));
         chk("req_ready", req_ready, t_known && e > t);
         chk("done", done, t_known && e == t && succ);
         chk("timeout", timeout, t_known && e == t && !succ);
         chk("mgmt_write", mgmt_write, q.size() != 0);
         if (prev_stall) begin
            chk("hold_addr", mgmt_address, pa);
            chk("hold_data", mgmt_writedata, pd);
         end
         if (mgmt_write && mgmt_address == 6'h04) m_cnt++;
         if (mgmt_write && !mgmt_waitrequest) begin
            if (q.size() == 0) begin
               chk("extra_write", 1, 0);
            end else begin
               w = q.pop_front();
               chk("wr_addr", mgmt_address, w[37:32]);
               chk("wr_data", mgmt_writedata, w[31:0]);
               if (q.size() == 0) begin
                  s = e + 1; s_known = 1; t_known = 1;
                  succ = (lock_d >= 0) && (lock_d <= LT - 1);
                  t = succ ? s + SC + 1 + lock_d : s + SC + LT;
               end
            end
         end
         prev_stall = mgmt_write && mgmt_waitrequest;
         pa = mgmt_address;
         pd = mgmt_writedata;
         if (t_known && e == t + 1) fin = 1;
         else begin
            @(posedge clk);
            e++;
         end
      end
      if (!fin) chk("cycle_budget", 0, 1);
      if (stall_m5) chk("m_held_cycles", m_cnt, 6);
      req_valid = 1'b0; pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Reset asserted while the K write is stalled.
   task automatic reset_mid_wrk();
      bit hit;
      hit = 0;
      req_mask = 4'hF; req_n = 18'h1; req_m = 18'h2; req_k = 32'h3;
      req_c_sel = 5'd1; req_c = 18'h4; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         if (mgmt_write && mgmt_address == 6'h07) begin
            hit = 1;
            mgmt_waitrequest = 1'b1;
         end else begin
            mgmt_waitrequest = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      chk("reach_wr_k", hit, 1);
      @(posedge clk);
      #1;
      chk("wr_k_stalled", {mgmt_write, mgmt_address}, {1'b1, 6'h07});
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_write", mgmt_write, 1);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mgmt_write", mgmt_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 1);
      chk("rst_addr", mgmt_address, 0);
      rst_n = 1'b1;
      mgmt_waitrequest = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_mask = '0; req_n = '0; req_m = '0;
      req_k = '0; req_c_sel = '0; req_c = '0; mgmt_waitrequest = 1'b0;
      pll_locked = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", req_ready, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_timeout", timeout, 0);
      chk("reset_write", mgmt_write, 0);
      chk("reset_addr", mgmt_address, 0);
      chk("reset_data", mgmt_writedata, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_req(4'hF, 18'h10000, 18'h00909, 32'h0, 5'd2, 18'h00909, 0, 0, 3, 0);
      run_req(4'b1000, 18'h0, 18'h0, 32'h0, 5'd4, 18'h20E0D, 0, 0, 2, 0);
      run_req(4'hF, 18'h3, 18'h2A5A5, 32'hDEADBEEF, 5'd17, 18'h1, 0, 1, 0, 0);
      run_req(4'hF, 18'h5, 18'h6, 32'h7, 5'd3, 18'h8, 0, 0, -1, 0);
      run_req(4'h0, 18'h0, 18'h0, 32'h0, 5'd0, 18'h0, 0, 0, 0, 0);
      run_req(4'b0101, 18'h1FFFF, 18'h0, 32'h12345678, 5'd31, 18'h3FFFF, 0, 0, LT - 1, 1);
      run_req(4'b0010, 18'h0, 18'h11111, 32'h0, 5'd0, 18'h0, 0, 0, LT, 1);
      reset_mid_wrk();
      run_req(4'hF, 18'h10000, 18'h00909, 32'h0, 5'd2, 18'h00909, 0, 0, 3, 0);

      for (int r = 0; r < 30; r++) begin
         run_req(4'($urandom), 18'($urandom), 18'($urandom), $urandom,
                 5'($urandom_range(0, 17)), 18'($urandom),
                 $urandom_range(0, 50), 0, $urandom_range(0, 23) - 1,
                 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Avalon-MM master sequencer that drives the management port of the PLL reconfiguration core, which in turn drives the PLL's 64-bit reconfig_to_pll/reconfig_from_pll buses.
- Accepts one retune request (N, M, K fraction, one C counter) and issues the ordered register writes, then the start write.
- Waits for PLL relock and reports done or timeout.
- Sits in the system clock domain next to the clock-generation block; used for runtime video/CPU clock changes.

Parameters:
- SETTLE_CYCLES, 16, cycles to wait after the start write is accepted before sampling pll_locked.
- LOCK_TIMEOUT, 1000000, maximum cycles to wait for pll_locked high after settle; range 1..2^24-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_mask  in  4  write enables: bit0 N, bit1 M, bit2 K, bit3 C.
- req_n  in  18  N register image: [17] odd, [16] bypass, [15:8] hi, [7:0] lo.
- req_m  in  18  M register image, same encoding as req_n.
- req_k  in  32  fractional K value.
- req_c_sel  in  5  C counter index 0..17.
- req_c  in  18  C register image, same encoding as req_n.
- mgmt_address  out  6  reconfig core register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_waitrequest  in  1  core stall.
- pll_locked  in  1  PLL lock, already synchronous to clk.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout  out  1  one-cycle pulse on lock timeout.

Behaviour:
- Reset: state IDLE, req_ready=1, busy=0, done=0, timeout=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0, counters 0, latched fields 0.
- Accept: on req_valid&&req_ready, latch all req_* fields. req_ready drops the next cycle.
- mask==0: go to FIN; done pulses 1 cycle after accept. No bus traffic.
- States in fixed order: IDLE -> MODE -> WR_N -> WR_M -> WR_K -> WR_C -> START -> SETTLE -> WAIT_LOCK -> FIN -> IDLE.
- Write states whose mask bit is clear are skipped with no cycle cost; transition is to the next enabled write or START.
- Write addresses and data:
  - MODE: addr 0x00, data 0 (waitrequest mode).
  - WR_N: addr 0x03, data {14'b0,n}.
  - WR_M: addr 0x04, data {14'b0,m}.
  - WR_K: addr 0x07, data k.
  - WR_C: addr 0x05, data {9'b0,c_sel,c}.
  - START: addr 0x02, data 1.
- Avalon write rule: mgmt_write, address and data are registered and become valid the cycle after the state is entered. They are held stable while mgmt_waitrequest=1. The write is accepted on the first edge with mgmt_write=1 and mgmt_waitrequest=0. On acceptance, mgmt_write drops unless the next state is also a write, in which case the new address/data are presented the next cycle. Minimum cost is one cycle per write when waitrequest=0.
- SETTLE: count SETTLE_CYCLES cycles, ignoring pll_locked.
- WAIT_LOCK: the 24-bit counter starts at 0 and increments each cycle.
  - If pll_locked=1: go to FIN with success.
  - If the counter reaches LOCK_TIMEOUT-1 with pll_locked=0: go to FIN with failure.
  - If pll_locked=1 on the same cycle as the limit, success wins.
- FIN: exactly one of done or timeout pulses for one cycle, then IDLE. req_ready returns 1 the cycle after the pulse.
- req_valid while busy is ignored; there is no queueing.
- pll_locked glitches outside WAIT_LOCK are ignored.
- Reset mid-operation: at the reset edge all outputs return to reset values immediately, including mgmt_write dropped mid-stall. The reconfig core shares rst_n, so this is legal.
- Invalid req_c_sel>17 is passed through unchanged; the block does not range-check it.

Test Plan:
1. Full request: mask=4'hF, n=18'h10000, m=18'h00909, k=32'h0, c_sel=2, c=18'h00909, waitrequest=0, locked rises 3 cycles after settle.
   - Expect writes in order: (00,0), (03,0x10000), (04,0x909), (07,0), (05,0x80909), (02,1) on consecutive cycles.
   - Expect done pulse, timeout=0.
2. mask=4'b1000, c_sel=4, c=18'h20E0D.
   - Expect only (00,0), (05,0x120E0D), (02,1).
   - Expect done after settle+lock.
3. Waitrequest=1 for 5 cycles during the WR_M write.
   - Expect address 0x04 and data held stable for 6 cycles, one accepted write, no duplicate.
4. LOCK_TIMEOUT=20, pll_locked held 0.
   - Expect timeout pulse exactly 20 cycles after SETTLE ends, done=0, req_ready=1 the next cycle.
5. mask=0.
   - Expect no mgmt_write, done pulse 1 cycle after accept, busy high for exactly 1 cycle.
6. rst_n=0 during the WR_K stall.
   - Expect mgmt_write=0, busy=0, req_ready=1 the next cycle.
   - A new request after reset runs the full sequence correctly.
